// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a Wishbone
// classic slave register file (CTRL, DATA, PERIOD, BLANK).
//
// Bus handshake: a request is valid when wbs_stb_i & wbs_cyc_i are high
// while wbs_ack_o is low; the slave is always ready and answers with a
// single-cycle wbs_ack_o on the following cycle, carrying read data on
// wbs_dat_o in that cycle only. A write takes effect at the sampling edge.
module seven_seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [6:0]          seg_out,
    output logic [DIGITS-1:0]   dig_en,
    output logic [DIGITS+6:0]   io_oeb,
    output logic [1:0]          fsm_state
);

    localparam int IDX_W = $clog2(DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Register file
    logic [1:0]       ctrl_q;
    logic [31:0]      data_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] blank_q;

    logic ctrl_en;
    logic ctrl_hex;
    assign ctrl_en  = ctrl_q[0];
    assign ctrl_hex = ctrl_q[1];

    // Scan datapath
    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [6:0]       shadow_q, shadow_nxt;
    logic [6:0]       seg_nxt;
    logic [DIGITS-1:0] dig_nxt;
    logic             enter_digit;
    logic [CNT_W-1:0] show_load;

    // Bus decode
    logic        bus_req;
    logic [31:0] rd_val;
    logic [31:0] wr_val;
    logic        adr_unused;

    assign fsm_state  = state_q;
    assign bus_req    = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign adr_unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    // Hex nibble to {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Read mux; unused bits read as zero.
    always_comb begin
        rd_val = '0;
        case (wbs_adr_i[3:2])
            2'd0: rd_val = {30'b0, ctrl_q};
            2'd1: rd_val = data_q;
            2'd2: rd_val = 32'(period_q);
            default: rd_val = 32'(blank_q);
        endcase
    end

    assign wr_val = merge_bytes(rd_val, wbs_dat_i, wbs_sel_i);

    // Bus slave: single-cycle ack, registered read data, byte-lane writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            ctrl_q    <= '0;
            data_q    <= '0;
            period_q  <= CNT_W'(16'h0400);
            blank_q   <= CNT_W'(16'h0010);
        end else begin
            wbs_ack_o <= bus_req;
            wbs_dat_o <= bus_req ? rd_val : '0;
            if (bus_req && wbs_we_i) begin
                case (wbs_adr_i[3:2])
                    2'd0: ctrl_q   <= wr_val[1:0];
                    2'd1: data_q   <= wr_val;
                    2'd2: period_q <= wr_val[CNT_W-1:0];
                    default: blank_q <= wr_val[CNT_W-1:0];
                endcase
            end
        end
    end

    // A zero PERIOD still shows the digit for one cycle.
    assign show_load = (period_q == '0) ? '0 : period_q - CNT_W'(1);

    // Next-state logic: counters load at phase start, so PERIOD/BLANK
    // changes only apply from the next phase onwards.
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        idx_nxt     = idx_q;
        shadow_nxt  = shadow_q;
        enter_digit = 1'b0;
        if (!ctrl_en) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_nxt     = '0;
                    enter_digit = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        state_nxt = ST_SHOW;
                        cnt_nxt   = show_load;
                    end else begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == '0) begin
                        idx_nxt     = idx_q + IDX_W'(1);
                        enter_digit = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
            // New digit: capture its DATA byte so later writes cannot
            // disturb the digit currently being displayed.
            if (enter_digit) begin
                shadow_nxt = data_q[{idx_nxt, 3'b000} +: 7];
                if (blank_q == '0) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = show_load;
                end else begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = blank_q - CNT_W'(1);
                end
            end
        end
    end

    // Output values derived from the next state so they align with it.
    always_comb begin
        seg_nxt = '0;
        dig_nxt = '0;
        if (state_nxt == ST_SHOW) begin
            dig_nxt = {{(DIGITS-1){1'b0}}, 1'b1} << idx_nxt;
            seg_nxt = ctrl_hex ? hex_seg(shadow_nxt[3:0]) : shadow_nxt;
        end
    end

    // Scan state and registered pad outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            seg_out  <= '0;
            dig_en   <= '0;
            io_oeb   <= '1;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            idx_q    <= idx_nxt;
            shadow_q <= shadow_nxt;
            seg_out  <= seg_nxt;
            dig_en   <= dig_nxt;
            io_oeb   <= {(DIGITS+7){~ctrl_en}};
        end
    end

endmodule
